// File: rtl/bram_burst_master.sv
// Burst initiator for one bram port: converts start-address/length commands into
// per-word bram accesses, with write beats from a stream and read beats to a stream.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bram_burst_master #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_busy,
  output logic                  o_bram_write,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  input  logic [DATA_WIDTH-1:0] i_bram_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_head_valid;
  logic                  r_head_last;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic                  r_tail_valid;
  logic                  r_tail_last;
  logic [DATA_WIDTH-1:0] r_tail_data;

  logic       w_cmd_hs;
  logic       w_wr_hs;
  logic       w_pop;
  logic [1:0] w_occ;
  logic       w_rd_issue;
  logic       w_last_beat;
  logic       w_drain_done;

  assign w_cmd_hs    = i_cmd_valid && (r_state == S_IDLE);
  assign w_wr_hs     = i_wr_valid && (r_state == S_WRITE);
  assign w_pop       = r_head_valid && i_rd_ready;
  assign w_last_beat = (r_remaining == '0);

  // Buffered beats plus the one in the bram pipeline must leave room for a new issue,
  // counting the slot freed by a pop happening this cycle.
  assign w_occ      = {1'b0, r_head_valid} + {1'b0, r_tail_valid} + {1'b0, r_inflight};
  assign w_rd_issue = (r_state == S_READ) && ((w_occ - {1'b0, w_pop}) < 2'd2);

  assign w_drain_done = w_pop && r_head_last && !r_tail_valid && !r_inflight;

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_wr_ready   = (r_state == S_WRITE);
  assign o_bram_write = w_wr_hs;
  assign o_bram_addr  = (w_wr_hs || w_rd_issue) ? r_cur_addr : '0;
  assign o_bram_data  = w_wr_hs ? i_wr_data : '0;
  assign o_rd_valid   = r_head_valid;
  assign o_rd_data    = r_head_data;
  assign o_rd_last    = r_head_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_cur_addr  <= i_cmd_addr;
            r_remaining <= i_cmd_len;
            r_state     <= i_cmd_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (w_wr_hs) begin
            r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
            if (w_last_beat) r_state <= S_IDLE;
            else r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
        end
        S_READ: begin
          if (w_rd_issue) begin
            r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
            if (w_last_beat) r_state <= S_DRAIN;
            else r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-entry response FIFO: head drives the read stream, tail absorbs a beat under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_head_valid    <= 1'b0;
      r_head_last     <= 1'b0;
      r_head_data     <= '0;
      r_tail_valid    <= 1'b0;
      r_tail_last     <= 1'b0;
      r_tail_data     <= '0;
    end else begin
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue && w_last_beat;
      if (w_pop) begin
        if (r_tail_valid) begin
          r_head_valid <= 1'b1;
          r_head_data  <= r_tail_data;
          r_head_last  <= r_tail_last;
          r_tail_valid <= r_inflight;
          r_tail_data  <= i_bram_data;
          r_tail_last  <= r_inflight_last;
        end else begin
          r_head_valid <= r_inflight;
          r_head_data  <= i_bram_data;
          r_head_last  <= r_inflight_last;
        end
      end else if (!r_head_valid) begin
        r_head_valid <= r_inflight;
        r_head_data  <= i_bram_data;
        r_head_last  <= r_inflight_last;
      end else if (r_inflight) begin
        r_tail_valid <= 1'b1;
        r_tail_data  <= i_bram_data;
        r_tail_last  <= r_inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a 1-cycle-latency bram model attached.
module tb_bram_burst_master;

  logic        i_clk;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [11:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [7:0]  i_wr_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_last;
  logic        o_busy;
  logic        o_bram_write;
  logic [11:0] o_bram_addr;
  logic [7:0]  o_bram_data;
  logic [7:0]  i_bram_data;

  logic [7:0] mem [0:4095];
  logic [7:0] expData [0:15];
  int checks = 0;
  int errors = 0;

  bram_burst_master #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .LEN_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_busy(o_busy), .o_bram_write(o_bram_write), .o_bram_addr(o_bram_addr),
    .o_bram_data(o_bram_data), .i_bram_data(i_bram_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_bram_write) mem[o_bram_addr] <= o_bram_data;
    i_bram_data <= mem[o_bram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cmdValid, input logic cmdWrite, input logic [11:0] addr,
                               input logic [7:0] len, input logic wrValid, input logic [7:0] wrData,
                               input logic rdReady);
    i_cmd_valid = cmdValid;
    i_cmd_write = cmdWrite;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    i_wr_valid  = wrValid;
    i_wr_data   = wrData;
    i_rd_ready  = rdReady;
  endtask

  task automatic writeBurst(input logic [11:0] addr, input int n, input bit gaps,
                            input bit holdNext, input logic [11:0] nextAddr);
    int k;
    logic [11:0] expAddr;
    @(negedge i_clk);
    applyStimulus(1'b1, 1'b1, addr, 8'(n - 1), 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("wr_cmd_ready", o_cmd_ready, 1);
    checkOutput("wr_idle_strobe", o_bram_write, 0);
    k = 0;
    for (int cyc = 1; cyc <= 64 && k < n; cyc++) begin
      @(negedge i_clk);
      if (holdNext) applyStimulus(1'b1, 1'b0, nextAddr, 8'h00, 1'b1, expData[k], 1'b0);
      else          applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, expData[k], 1'b0);
      if (gaps) i_wr_valid = ((cyc - 1) % 2 == 0);
      #1;
      checkOutput("wr_ready", o_wr_ready, 1);
      checkOutput("wr_busy", o_busy, 1);
      if (holdNext) checkOutput("wr_cmd_blocked", o_cmd_ready, 0);
      checkOutput("wr_strobe", o_bram_write, i_wr_valid);
      if (i_wr_valid) begin
        expAddr = addr + 12'(k);
        checkOutput("wr_addr", o_bram_addr, expAddr);
        checkOutput("wr_data", o_bram_data, expData[k]);
        k++;
      end
    end
    checkOutput("wr_beat_count", k, n);
    @(negedge i_clk);
    i_wr_valid = 1'b1;
    #1;
    checkOutput("wr_done_strobe", o_bram_write, 0);
    checkOutput("wr_done_ready", o_wr_ready, 0);
    checkOutput("wr_done_busy", o_busy, 0);
    checkOutput("wr_done_cmd_ready", o_cmd_ready, 1);
  endtask

  task automatic collectRead(input int n, input bit toggle, input int limit);
    int got, firstCyc, fifoTb, inflightTb, issues, popI, issueI;
    got = 0; firstCyc = -1; fifoTb = 0; inflightTb = 0; issues = 0;
    for (int cyc = 1; cyc <= 64 && got < limit; cyc++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      i_rd_ready  = toggle ? ((cyc - 1) % 3 == 0) : 1'b1;
      #1;
      if (o_rd_valid && firstCyc < 0) firstCyc = cyc;
      popI = (o_rd_valid && i_rd_ready) ? 1 : 0;
      checkOutput("rd_no_write_strobe", o_bram_write, 0);
      if (toggle) begin
        issueI = (o_bram_addr != 12'h000) ? 1 : 0;
        if (issueI == 1) begin
          checkOutput("rd_overissue", (fifoTb + inflightTb - popI) < 2, 1);
          issues++;
        end
        fifoTb     = fifoTb + inflightTb - popI;
        inflightTb = issueI;
      end
      if (popI == 1) begin
        checkOutput("rd_data", o_rd_data, expData[got]);
        checkOutput("rd_last", o_rd_last, (got == n - 1));
        got++;
      end
    end
    checkOutput("rd_beat_count", got, limit);
    checkOutput("rd_first_latency", firstCyc, 3);
    if (toggle) checkOutput("rd_issue_count", issues, n);
    if (limit == n) begin
      @(negedge i_clk);
      i_rd_ready = 1'b0;
      #1;
      checkOutput("rd_done_valid", o_rd_valid, 0);
      checkOutput("rd_done_busy", o_busy, 0);
      checkOutput("rd_done_cmd_ready", o_cmd_ready, 1);
    end
  endtask

  task automatic readBurst(input logic [11:0] addr, input int n, input bit toggle, input int limit);
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = addr;
    i_cmd_len   = 8'(n - 1);
    i_rd_ready  = 1'b0;
    #1;
    checkOutput("rd_cmd_ready", o_cmd_ready, 1);
    collectRead(n, toggle, limit);
  endtask

  initial begin
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    checkOutput("rst_cmd_ready", o_cmd_ready, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_wr_ready", o_wr_ready, 0);
    checkOutput("rst_rd_valid", o_rd_valid, 0);
    checkOutput("rst_rd_last", o_rd_last, 0);
    checkOutput("rst_bram_write", o_bram_write, 0);
    checkOutput("rst_bram_addr", o_bram_addr, 0);
    checkOutput("rst_bram_data", o_bram_data, 0);
    i_rst = 1'b0;

    expData[0] = 8'hAA; expData[1] = 8'hBB; expData[2] = 8'hCC; expData[3] = 8'hDD;
    writeBurst(12'h000, 4, 1'b0, 1'b0, 12'h000);
    readBurst(12'h000, 4, 1'b0, 4);

    // Abort a read after two beats have been taken
    readBurst(12'h000, 4, 1'b0, 2);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_rd_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("abort_rd_valid", o_rd_valid, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_cmd_ready", o_cmd_ready, 1);
    expData[0] = 8'hBB;
    readBurst(12'h001, 1, 1'b0, 1);

    expData[0] = 8'h61; expData[1] = 8'h62; expData[2] = 8'h63;
    writeBurst(12'h020, 3, 1'b1, 1'b0, 12'h000);

    for (int i = 0; i < 8; i++) expData[i] = 8'(8'h11 + i);
    writeBurst(12'h100, 8, 1'b0, 1'b0, 12'h000);
    readBurst(12'h100, 8, 1'b1, 8);

    expData[0] = 8'h41; expData[1] = 8'h42; expData[2] = 8'h43; expData[3] = 8'h44;
    writeBurst(12'hFFE, 4, 1'b0, 1'b0, 12'h000);
    readBurst(12'hFFE, 4, 1'b0, 4);

    // Read command held valid across a write is taken once the write returns to idle
    expData[0] = 8'h71; expData[1] = 8'h72;
    writeBurst(12'h030, 2, 1'b0, 1'b1, 12'h031);
    expData[0] = 8'h72;
    collectRead(1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
